// File: rtl/amo_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : amo_sequencer
// Description : RV64A LR/SC and AMO read-modify-write sequencer with LR
//               reservation tracking, driven from the execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
module amo_sequencer #(
  parameter int N        = 64,
  parameter int RES_GRAN = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [4:0]   funct5,
  input  logic         wordOp,
  input  logic [N-1:0] addr_E,
  input  logic [N-1:0] rs2_E,
  input  logic         snoop_valid,
  input  logic [N-1:0] snoop_addr,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic         mem_ack,
  input  logic [N-1:0] mem_rdata,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result_rd,
  output logic         fault
);

  localparam logic [4:0] c_AMOADD  = 5'b00000;
  localparam logic [4:0] c_AMOSWAP = 5'b00001;
  localparam logic [4:0] c_LR      = 5'b00010;
  localparam logic [4:0] c_SC      = 5'b00011;
  localparam logic [4:0] c_AMOXOR  = 5'b00100;
  localparam logic [4:0] c_AMOOR   = 5'b01000;
  localparam logic [4:0] c_AMOAND  = 5'b01100;
  localparam logic [4:0] c_AMOMIN  = 5'b10000;
  localparam logic [4:0] c_AMOMAX  = 5'b10100;
  localparam logic [4:0] c_AMOMINU = 5'b11000;
  localparam logic [4:0] c_AMOMAXU = 5'b11100;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_CALC  = 3'd2,
    S_WRITE = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [4:0]     r_funct5;
  logic           r_word;
  logic [N-1:0]   r_addr;
  logic [N-1:0]   r_rs2;
  logic [N-1:0]   r_old;
  logic [N-1:0]   r_wdata;
  logic [N-1:0]   r_result;
  logic           r_fault;
  logic           r_res_valid;
  logic [N-1:0]   r_res_addr;

  logic           w_known;
  logic           w_misaligned;
  logic           w_bad;
  logic           w_sc_hit;
  logic           w_snoop_hit;
  logic           w_lr_set;
  logic [N-1:0]   w_rs2_ext;
  logic [N-1:0]   w_rd_ext;
  logic [N-1:0]   w_as, w_bs, w_au, w_bu;
  logic           w_lt_s, w_lt_u;
  logic [N-1:0]   w_new;
  logic [N-1:0]   w_new_ext;

  always_comb begin
    w_known = 1'b0;
    case (funct5)
      c_AMOADD, c_AMOSWAP, c_LR, c_SC, c_AMOXOR, c_AMOOR, c_AMOAND,
      c_AMOMIN, c_AMOMAX, c_AMOMINU, c_AMOMAXU: w_known = 1'b1;
      default:                                  w_known = 1'b0;
    endcase
  end

  assign w_misaligned = wordOp ? (addr_E[1:0] != 2'b00) : (addr_E[2:0] != 3'b000);
  assign w_bad        = w_misaligned || !w_known;

  // Granule match ignores the low RES_GRAN address bits.
  assign w_sc_hit    = r_res_valid && (((addr_E ^ r_res_addr) >> RES_GRAN) == '0);
  assign w_snoop_hit = snoop_valid && r_res_valid &&
                       (((snoop_addr ^ r_res_addr) >> RES_GRAN) == '0);
  assign w_lr_set    = (r_state == S_READ) && mem_ack && (r_funct5 == c_LR);

  assign w_rs2_ext = wordOp ? {{(N-32){1'b0}}, rs2_E[31:0]} : rs2_E;
  assign w_rd_ext  = r_word ? {{(N-32){mem_rdata[31]}}, mem_rdata[31:0]} : mem_rdata;

  assign w_as   = r_word ? {{(N-32){r_old[31]}}, r_old[31:0]} : r_old;
  assign w_bs   = r_word ? {{(N-32){r_rs2[31]}}, r_rs2[31:0]} : r_rs2;
  assign w_au   = r_word ? {{(N-32){1'b0}}, r_old[31:0]} : r_old;
  assign w_bu   = r_word ? {{(N-32){1'b0}}, r_rs2[31:0]} : r_rs2;
  assign w_lt_s = $signed(w_as) < $signed(w_bs);
  assign w_lt_u = w_au < w_bu;

  always_comb begin
    w_new = w_bs;
    case (r_funct5)
      c_AMOSWAP: w_new = w_bs;
      c_AMOADD:  w_new = w_as + w_bs;
      c_AMOXOR:  w_new = w_as ^ w_bs;
      c_AMOAND:  w_new = w_as & w_bs;
      c_AMOOR:   w_new = w_as | w_bs;
      c_AMOMIN:  w_new = w_lt_s ? w_as : w_bs;
      c_AMOMAX:  w_new = w_lt_s ? w_bs : w_as;
      c_AMOMINU: w_new = w_lt_u ? w_au : w_bu;
      c_AMOMAXU: w_new = w_lt_u ? w_bu : w_au;
      default:   w_new = w_bs;
    endcase
  end

  assign w_new_ext = r_word ? {{(N-32){1'b0}}, w_new[31:0]} : w_new;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (w_bad)                 w_state_nxt = S_FIN;
          else if (funct5 == c_SC)   w_state_nxt = w_sc_hit ? S_WRITE : S_FIN;
          else                       w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        mem_req = 1'b1;
        if (mem_ack) w_state_nxt = (r_funct5 == c_LR) ? S_FIN : S_CALC;
      end
      S_CALC: w_state_nxt = S_WRITE;
      S_WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) w_state_nxt = S_FIN;
      end
      S_FIN: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign result_rd = done ? r_result : '0;
  assign fault     = done & r_fault;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_funct5    <= '0;
      r_word      <= 1'b0;
      r_addr      <= '0;
      r_rs2       <= '0;
      r_old       <= '0;
      r_wdata     <= '0;
      r_result    <= '0;
      r_fault     <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_addr  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_funct5 <= funct5;
            r_word   <= wordOp;
            r_addr   <= addr_E;
            r_rs2    <= rs2_E;
            r_fault  <= w_bad;
            r_result <= '0;
            r_wdata  <= '0;
            if (!w_bad && funct5 == c_SC) begin
              r_result <= {{(N-1){1'b0}}, !w_sc_hit};
              r_wdata  <= w_rs2_ext;
            end
          end
        end
        S_READ: begin
          if (mem_ack) begin
            r_old    <= mem_rdata;
            r_result <= w_rd_ext;
          end
        end
        S_CALC:  r_wdata <= w_new_ext;
        default: ;
      endcase

      // An LR completing in the same cycle as a matching snoop keeps its reservation.
      if (w_lr_set) begin
        r_res_valid <= 1'b1;
        r_res_addr  <= r_addr;
      end else if ((r_state == S_IDLE && start && funct5 == c_SC) || w_snoop_hit) begin
        r_res_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_amo_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_amo_sequencer
// Description : Directed self-checking bench for amo_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_amo_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [4:0]  funct5;
  logic        wordOp;
  logic [63:0] addr_E;
  logic [63:0] rs2_E;
  logic        snoop_valid;
  logic [63:0] snoop_addr;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        busy;
  logic        done;
  logic [63:0] result_rd;
  logic        fault;

  int checks = 0;
  int errors = 0;
  int ack_delay = 0;
  int req_cycles = 0;
  logic [63:0] mem [logic [63:0]];

  amo_sequencer #(.N(64), .RES_GRAN(3)) dut (
    .clk(clk), .reset(reset), .start(start), .funct5(funct5), .wordOp(wordOp),
    .addr_E(addr_E), .rs2_E(rs2_E), .snoop_valid(snoop_valid), .snoop_addr(snoop_addr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy), .done(done),
    .result_rd(result_rd), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: acks after ack_delay extra request cycles.
  always @(negedge clk) begin
    if (reset || !mem_req) begin
      mem_ack    = 1'b0;
      req_cycles = 0;
    end else if (req_cycles >= ack_delay) begin
      mem_ack    = 1'b1;
      req_cycles = 0;
      if (mem_we) mem[mem_addr] = mem_wdata;
      else        mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 64'h0;
    end else begin
      mem_ack    = 1'b0;
      req_cycles = req_cycles + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [4:0] f5, input logic w,
                        input logic [63:0] a, input logic [63:0] d,
                        output int lat, output logic [63:0] rd, output logic flt,
                        output logic rq, output int wc);
    @(negedge clk);
    start = 1'b1; funct5 = f5; wordOp = w; addr_E = a; rs2_E = d;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; rd = '0; flt = 1'b0; rq = 1'b0; wc = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (mem_req) rq = 1'b1;
      if (mem_req && mem_we && wc == 0) wc = lat;
      if (done) begin
        rd  = result_rd;
        flt = fault;
        break;
      end
    end
    chk({tag, "_done"}, {63'b0, done}, 64'd1);
    @(negedge clk);
    chk({tag, "_pulse"}, {62'b0, done, busy}, 64'd0);
  endtask

  int          lat, wc, rdreq;
  logic [63:0] rd;
  logic        flt, rq, found, done_seen;

  initial begin
    reset = 1'b1; start = 1'b0; funct5 = '0; wordOp = 1'b0; addr_E = '0; rs2_E = '0;
    snoop_valid = 1'b0; snoop_addr = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {60'b0, busy, done, mem_req, mem_we}, 64'd0);
    chk("rst_fault", {63'b0, fault}, 64'd0);
    chk("rst_addr", mem_addr, 64'd0);
    chk("rst_wdata", mem_wdata, 64'd0);
    chk("rst_rd", result_rd, 64'd0);
    reset = 1'b0;

    // AMOADD.W wraps into bit 31; upper word of store is zero
    mem[64'h100] = 64'h0000_0000_7FFF_FFFF;
    run_op("addw", 5'b00000, 1'b1, 64'h100, 64'd1, lat, rd, flt, rq, wc);
    chk("addw_lat", lat, 64'd4);
    chk("addw_wcyc", wc, 64'd3);
    chk("addw_rd", rd, 64'h0000_0000_7FFF_FFFF);
    chk("addw_flt", {63'b0, flt}, 64'd0);
    chk("addw_mem", mem[64'h100], 64'h0000_0000_8000_0000);

    mem[64'h108] = 64'hFFFF_FFFF_FFFF_FFFE;
    run_op("mind", 5'b10000, 1'b0, 64'h108, 64'd5, lat, rd, flt, rq, wc);
    chk("mind_rd", rd, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("mind_mem", mem[64'h108], 64'hFFFF_FFFF_FFFF_FFFE);
    chk("mind_wcyc", wc, 64'd3);
    run_op("minud", 5'b11000, 1'b0, 64'h108, 64'd5, lat, rd, flt, rq, wc);
    chk("minud_rd", rd, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("minud_mem", mem[64'h108], 64'd5);

    // AMOMAX.W: 0x80000000 is the most negative word; upper bits ignored
    mem[64'h110] = 64'hDEAD_BEEF_8000_0000;
    run_op("maxw", 5'b10100, 1'b1, 64'h110, 64'hFFFF_FFFF_0000_0003, lat, rd, flt, rq, wc);
    chk("maxw_rd", rd, 64'hFFFF_FFFF_8000_0000);
    chk("maxw_mem", mem[64'h110], 64'h0000_0000_0000_0003);

    mem[64'h200] = 64'h1234;
    run_op("lrd", 5'b00010, 1'b0, 64'h200, 64'd0, lat, rd, flt, rq, wc);
    chk("lrd_lat", lat, 64'd2);
    chk("lrd_rd", rd, 64'h1234);
    run_op("scd", 5'b00011, 1'b0, 64'h200, 64'hAB, lat, rd, flt, rq, wc);
    chk("scd_lat", lat, 64'd2);
    chk("scd_rd", rd, 64'd0);
    chk("scd_mem", mem[64'h200], 64'hAB);
    run_op("scd2", 5'b00011, 1'b0, 64'h200, 64'hCD, lat, rd, flt, rq, wc);
    chk("scd2_lat", lat, 64'd1);
    chk("scd2_rd", rd, 64'd1);
    chk("scd2_req", {63'b0, rq}, 64'd0);

    mem[64'h300] = 64'h0000_0000_FFFF_FFF0;
    run_op("lrw", 5'b00010, 1'b1, 64'h300, 64'd0, lat, rd, flt, rq, wc);
    chk("lrw_rd", rd, 64'hFFFF_FFFF_FFFF_FFF0);
    @(negedge clk); snoop_valid = 1'b1; snoop_addr = 64'h304;
    @(negedge clk); snoop_valid = 1'b0;
    run_op("scw", 5'b00011, 1'b1, 64'h300, 64'h55, lat, rd, flt, rq, wc);
    chk("scw_lat", lat, 64'd1);
    chk("scw_rd", rd, 64'd1);
    chk("scw_req", {63'b0, rq}, 64'd0);
    chk("scw_mem", mem[64'h300], 64'h0000_0000_FFFF_FFF0);

    run_op("misal", 5'b00001, 1'b1, 64'h102, 64'd9, lat, rd, flt, rq, wc);
    chk("misal_res", {lat[31:0], 30'b0, flt, rq}, {32'd1, 32'd2});
    chk("misal_rd", rd, 64'd0);
    run_op("ill", 5'b11111, 1'b0, 64'h100, 64'd9, lat, rd, flt, rq, wc);
    chk("ill_res", {lat[31:0], 30'b0, flt, rq}, {32'd1, 32'd2});

    // Reset during a stalled write aborts the op and drops the reservation
    mem[64'h400] = 64'h77;
    run_op("lr4", 5'b00010, 1'b0, 64'h400, 64'd0, lat, rd, flt, rq, wc);
    chk("lr4_rd", rd, 64'h77);
    ack_delay = 3;
    mem[64'h408] = 64'hF0;
    @(negedge clk);
    start = 1'b1; funct5 = 5'b01000; wordOp = 1'b0; addr_E = 64'h408; rs2_E = 64'h0F;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0; rdreq = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_req && !mem_we) rdreq++;
      if (mem_req && mem_we) begin
        found = 1'b1;
        break;
      end
    end
    chk("or_inwrite", {63'b0, found}, 64'd1);
    chk("or_rdreq", rdreq, 64'd4);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ctrl", {61'b0, mem_req, busy, done}, 64'd0);
    done_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    chk("abort_nodone", {63'b0, done_seen}, 64'd0);
    chk("abort_mem", mem[64'h408], 64'hF0);
    ack_delay = 0;
    run_op("sc4", 5'b00011, 1'b0, 64'h400, 64'd1, lat, rd, flt, rq, wc);
    chk("sc4_rd", rd, 64'd1);
    chk("sc4_req", {63'b0, rq}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/amo_sequencer.md
Name: amo_sequencer

Overview:
Multi-cycle controller for RV64A atomics (LR/SC and AMO read-modify-write) in the execute stage.
- Accepts one atomic op from decode and holds the pipeline via busy.
- Sequences the memory read, the combine step and the memory write-back over a req/ack data-memory port.
- Owns the LR reservation register.
- Returns the rd value and a one-cycle done pulse to writeback.

Parameters:
N, 64, data/address width
RES_GRAN, 3, log2 bytes of reservation granule (addr[N-1:RES_GRAN] compared)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  launch op; sampled only in IDLE
funct5  in  5  RV-A funct5 encoding
wordOp  in  1  1 = .W (32-bit), 0 = .D
addr_E  in  N  effective address (rs1)
rs2_E  in  N  operand / store data
snoop_valid  in  1  other-master or non-atomic store observed
snoop_addr  in  N  address of that store
mem_req  out  1  memory request
mem_we  out  1  1 = write
mem_addr  out  N  request address
mem_wdata  out  N  write data
mem_ack  in  1  request accepted/completed this cycle
mem_rdata  in  N  read data, valid when mem_ack && !mem_we
busy  out  1  stall pipeline
done  out  1  one-cycle completion pulse
result_rd  out  N  rd value, valid with done
fault  out  1  with done: misaligned or illegal funct5

Behaviour:
- Reset: state IDLE; all outputs 0; reservation invalid. Reset mid-operation aborts immediately, drops mem_req the next cycle, performs no write.
- States: IDLE, READ, CALC, WRITE, FIN.
  - IDLE, start=1: latch funct5/wordOp/addr/rs2.
    - Misaligned (wordOp ? addr[1:0]!=0 : addr[2:0]!=0) or unknown funct5 -> FIN with fault=1, result 0, no memory access.
    - SC -> WRITE if reservation valid and addr granule matches, else FIN with result 1.
    - Otherwise -> READ.
  - READ: mem_req=1, mem_we=0. On mem_ack, capture rdata. LR -> FIN, setting reservation {valid, addr}. AMO -> CALC.
  - CALC: compute new value, one cycle -> WRITE.
  - WRITE: mem_req=1, mem_we=1, mem_wdata = new value (SC: rs2). On mem_ack -> FIN.
  - FIN: done=1 for one cycle -> IDLE.
- busy=1 in every state except IDLE. start during busy is ignored.
- Handshake:
  - mem_addr, mem_we and mem_wdata are stable while mem_req=1.
  - mem_req holds until mem_ack.
  - An ack in the first cycle of req is accepted.
  - mem_req=0 in IDLE, CALC and FIN.
- Encodings:
  - LR 00010, SC 00011.
  - AMOSWAP 00001, AMOADD 00000, AMOXOR 00100, AMOAND 01100, AMOOR 01000.
  - AMOMIN 10000, AMOMAX 10100, AMOMINU 11000, AMOMAXU 11100.
- Width rules:
  - .W: operands are the low 32 bits; MIN/MAX compare signed 32-bit, MINU/MAXU unsigned 32-bit.
  - .W: wdata = {32'b0, new[31:0]}; result_rd = sign-extended old low word.
  - .D: full N bits. ADD wraps modulo 2^width; no overflow flag.
- Results:
  - AMO/LR: result_rd = old memory value.
  - SC: 0 on success, 1 on failure.
- Reservation:
  - Any SC clears the reservation, pass or fail.
  - A new LR overwrites the reservation.
  - snoop_valid with granule match clears it in any state. If this coincides with the LR-setting cycle, the LR set wins.
  - AMOs do not affect the reservation.
- Minimum latency with ack in the first req cycle (cycle 0 = start sampled):
  - AMO: done in cycle 4.
  - LR: done in cycle 2.
  - SC success: done in cycle 2.
  - SC fail or fault: done in cycle 1.

Test Plan:
- AMOADD.W, addr 0x100, mem[0x100]=0x7FFFFFFF, rs2=1, ack immediate -> write 0x0000000080000000 in cycle 3; done in cycle 4 with result_rd 0x000000007FFFFFFF.
- AMOMIN.D, mem=0xFFFFFFFFFFFFFFFE (-2), rs2=5 -> writes -2, rd -2. Repeat as AMOMINU.D -> writes 5, rd 0xFFFFFFFFFFFFFFFE.
- LR.D 0x200 then SC.D 0x200, rs2=0xAB -> write 0xAB, rd 0. A second SC.D 0x200 -> no mem_req, rd 1 in cycle 1.
- LR.W 0x300, then snoop_valid with snoop_addr 0x304 (granule 3) -> following SC.W 0x300 fails, rd 1, no write.
- AMOSWAP.W addr 0x102 -> no mem_req; done+fault in cycle 1. funct5=11111 -> same.
- AMOOR.D with mem_ack delayed 3 cycles in READ; assert reset in WRITE -> mem_req low the next cycle, busy 0, no done; a subsequent SC fails (reservation cleared).
